// File: rtl/prim_subreg_cdc_arb_pkg.sv
// Shared types for the register CDC write scheduler.
package prim_subreg_cdc_arb_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StWait = 2'd1,
    StDone = 2'd2
  } state_e;

endpackage

// File: rtl/prim_subreg_cdc_rr_arb.sv
// Combinational round-robin picker: lowest set request at or above ptr, wrapping.
module prim_subreg_cdc_rr_arb #(
  parameter int NumReq = 4,
  parameter int IW     = $clog2(NumReq)
) (
  input  logic [NumReq-1:0] req,
  input  logic [IW-1:0]     ptr,
  output logic [NumReq-1:0] gnt_onehot,
  output logic [IW-1:0]     idx,
  output logic              valid
);

  logic [NumReq-1:0]   mask;
  logic [2*NumReq-1:0] dbl;
  logic                found;

  // Upper copy is unmasked, so a miss above ptr falls through to the wrapped search.
  always_comb begin
    mask  = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < NumReq; i++) begin
      mask[i] = (IW'(i) >= ptr);
    end
    dbl = {req, req & mask};
    for (int i = 0; i < 2 * NumReq; i++) begin
      if (!found && dbl[i]) begin
        found = 1'b1;
        idx   = IW'(i % NumReq);
      end
    end
    valid      = |req;
    gnt_onehot = valid ? (NumReq'(1) << idx) : '0;
  end

endmodule

// File: rtl/prim_subreg_cdc_arb.sv
// Source-domain write scheduler for one register CDC channel: round-robin
// arbitration, one request in flight, periodic update pulse, hang detection.
//
// state  | meaning
// StIdle | channel free; grant when a request is pending and busy is low
// StWait | write issued; waiting for the channel to drop busy or time out
// StDone | one-cycle completion pulse to the owner; advance round-robin ptr
module prim_subreg_cdc_arb
  import prim_subreg_cdc_arb_pkg::*;
#(
  parameter int NumReq        = 4,
  parameter int DW            = 32,
  parameter int UpdatePeriod  = 16,
  parameter int TimeoutCycles = 1024
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [NumReq-1:0]        req_i,
  input  logic [NumReq-1:0][DW-1:0] wdata_i,
  output logic [NumReq-1:0]        gnt_o,
  output logic [NumReq-1:0]        done_o,
  output logic                     err_o,
  output logic [DW-1:0]            rdata_o,
  output logic                     cdc_req_o,
  output logic [DW-1:0]            cdc_data_o,
  output logic                     cdc_update_o,
  input  logic                     cdc_busy_i,
  input  logic [DW-1:0]            cdc_rdata_i,
  output logic                     timeout_o,
  input  logic                     clr_timeout_i
);

  localparam int IW = $clog2(NumReq);
  localparam int UW = $clog2(UpdatePeriod);
  localparam int TW = $clog2(TimeoutCycles + 1);

  state_e          state_q, state_d;
  logic [IW-1:0]   ptr_q, owner_q;
  logic [UW-1:0]   upd_cnt_q;
  logic [TW-1:0]   wait_cnt_q, wait_inc;
  logic            abort_q, timeout_q;
  logic [DW-1:0]   rdata_q;

  logic [NumReq-1:0] arb_gnt;
  logic [IW-1:0]     arb_idx;
  logic              arb_valid;
  logic              grant, wait_to;

  prim_subreg_cdc_rr_arb #(
    .NumReq (NumReq),
    .IW     (IW)
  ) u_rr_arb (
    .req        (req_i),
    .ptr        (ptr_q),
    .gnt_onehot (arb_gnt),
    .idx        (arb_idx),
    .valid      (arb_valid)
  );

  assign grant    = (state_q == StIdle) && arb_valid && !cdc_busy_i;
  assign wait_inc = wait_cnt_q + TW'(1);

  always_comb begin
    state_d      = state_q;
    gnt_o        = '0;
    cdc_req_o    = 1'b0;
    cdc_data_o   = '0;
    done_o       = '0;
    err_o        = 1'b0;
    cdc_update_o = 1'b0;
    wait_to      = 1'b0;
    case (state_q)
      StIdle: begin
        if (grant) begin
          gnt_o      = arb_gnt;
          cdc_req_o  = 1'b1;
          cdc_data_o = wdata_i[arb_idx];
          state_d    = StWait;
        end else if (upd_cnt_q == UW'(UpdatePeriod - 1)) begin
          cdc_update_o = 1'b1;
        end
      end
      StWait: begin
        // wait_cnt_q == 0 marks the first WAIT cycle, where busy is not yet valid.
        if (wait_cnt_q != '0 && !cdc_busy_i) begin
          state_d = StDone;
        end else if (wait_inc == TW'(TimeoutCycles)) begin
          wait_to = 1'b1;
          state_d = StDone;
        end
      end
      StDone: begin
        done_o  = NumReq'(1) << owner_q;
        err_o   = abort_q;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      ptr_q      <= '0;
      owner_q    <= '0;
      upd_cnt_q  <= '0;
      wait_cnt_q <= '0;
      abort_q    <= 1'b0;
      timeout_q  <= 1'b0;
      rdata_q    <= '0;
    end else begin
      state_q <= state_d;
      rdata_q <= cdc_rdata_i;

      if (grant) begin
        owner_q   <= arb_idx;
        upd_cnt_q <= '0;
      end else if (state_q == StIdle) begin
        upd_cnt_q <= cdc_update_o ? '0 : upd_cnt_q + UW'(1);
      end

      if (state_q == StWait) begin
        wait_cnt_q <= wait_inc;
      end else if (state_q == StDone) begin
        wait_cnt_q <= '0;
      end

      if (wait_to) begin
        abort_q <= 1'b1;
      end else if (state_q == StDone) begin
        abort_q <= 1'b0;
      end

      if (state_q == StDone) begin
        ptr_q <= (owner_q == IW'(NumReq - 1)) ? '0 : owner_q + IW'(1);
      end

      if (wait_to) begin
        timeout_q <= 1'b1;
      end else if (clr_timeout_i) begin
        timeout_q <= 1'b0;
      end
    end
  end

  assign timeout_o = timeout_q;
  assign rdata_o   = rdata_q;

endmodule
